color_decoder: RTL

- Receive end of the RGB LED interface: samples three active-low colour lines and recovers the colour-state index.
- The lines are driven by a colour-cycling board and are asynchronous to this block.
- Synchronises and deglitches the lines, decodes the RGB code to a state index, then checks that each accepted colour is the legal successor of the previous one.
- Sits on the monitor/self-check side of the colour-mixer datapath; its outputs feed status LEDs or a logger.

---
 rtl/color_decoder_pkg.sv | 43 ++++
 rtl/sync_stable.sv | 52 +++++
 rtl/color_decoder.sv | 92 +++++++++
 3 files changed

// File: rtl/color_decoder_pkg.sv
// Shared colour definitions for the RGB LED link: state indices, RGB codes and the decoder.
// Both ends of the link import this package so that their encodings stay in step.
package color_decoder_pkg;

    // RGB codes, bit order {r, g, b}, active-high
    localparam logic [2:0] IDLE    = 3'b000;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam logic [2:0] IDLE_S    = 3'd0;
    localparam logic [2:0] RED_S     = 3'd1;
    localparam logic [2:0] GREEN_S   = 3'd2;
    localparam logic [2:0] BLUE_S    = 3'd3;
    localparam logic [2:0] YELLOW_S  = 3'd4;
    localparam logic [2:0] CYAN_S    = 3'd5;
    localparam logic [2:0] MAGENTA_S = 3'd6;
    localparam logic [2:0] WHITE_S   = 3'd7;

    typedef enum logic {StAcquire, StLocked} dec_state_e;

    function automatic logic [2:0] decode_color(input logic [2:0] code);
        logic [2:0] idx;
        idx = IDLE_S;
        case (code)
            IDLE:    idx = IDLE_S;
            RED:     idx = RED_S;
            GREEN:   idx = GREEN_S;
            BLUE:    idx = BLUE_S;
            YELLOW:  idx = YELLOW_S;
            CYAN:    idx = CYAN_S;
            MAGENTA: idx = MAGENTA_S;
            WHITE:   idx = WHITE_S;
            default: idx = IDLE_S;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync_stable.sv
// Two-flop synchroniser for active-low lines plus a stability filter; emits the active-high code
// and a one-cycle accept pulse once that code has held for STABLE_CYCLES synchronised edges.
module sync_stable #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lines_n,
    output logic [WIDTH-1:0] code,
    output logic             accept_pulse
);

    localparam int unsigned CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] meta_q, sync_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             primed_q;
    logic             accept_q, accept_d;

    // The first edge after reset only refills the second stage, so it never counts as stable.
    always_comb begin
        cnt_d = cnt_q;
        if (!primed_q || (meta_q != sync_q)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_DONE) begin
            cnt_d = cnt_q + CW'(1);
        end
        accept_d = (cnt_d == CNT_DONE) && (cnt_q != CNT_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= '1;
            sync_q   <= '1;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            accept_q <= 1'b0;
        end else begin
            meta_q   <= lines_n;
            sync_q   <= meta_q;
            cnt_q    <= cnt_d;
            primed_q <= 1'b1;
            accept_q <= accept_d;
        end
    end

    assign code         = ~sync_q;
    assign accept_pulse = accept_q;

endmodule

// File: rtl/color_decoder.sv
// Receive end of the RGB LED link: recovers the colour-state index and checks that every
// accepted colour is the legal successor of the previous one.
module color_decoder
    import color_decoder_pkg::*;
#(
    parameter int unsigned NUM_STATES    = 8,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rLed_i,
    input  logic             gLed_i,
    input  logic             bLed_i,
    output logic [2:0]       color_o,
    output logic             valid_o,
    output logic             change_o,
    output logic             seq_err_o,
    output logic [CNT_W-1:0] change_count_o,
    output logic [CNT_W-1:0] err_count_o
);

    localparam logic [2:0]       LAST_IDX = 3'(NUM_STATES - 1);
    localparam logic [3:0]       N_IDX    = 4'(NUM_STATES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [2:0] code;
    logic       accept;
    logic [2:0] idx;
    logic [2:0] next_idx;
    logic       is_err;
    dec_state_e state_q;

    sync_stable #(
        .WIDTH        (3),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_sync_stable (
        .clk         (clk),
        .rst_n       (rst_n),
        .lines_n     ({rLed_i, gLed_i, bLed_i}),
        .code        (code),
        .accept_pulse(accept)
    );

    // An out-of-range colour wraps to 0 as well, so the next legal step resynchronises.
    always_comb begin
        idx      = decode_color(code);
        next_idx = (color_o >= LAST_IDX) ? 3'd0 : color_o + 3'd1;
        is_err   = (idx != next_idx) || ({1'b0, idx} >= N_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StAcquire;
            color_o        <= '0;
            valid_o        <= 1'b0;
            change_o       <= 1'b0;
            seq_err_o      <= 1'b0;
            change_count_o <= '0;
            err_count_o    <= '0;
        end else begin
            change_o  <= 1'b0;
            seq_err_o <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    StAcquire: begin
                        color_o <= idx;
                        valid_o <= 1'b1;
                        state_q <= StLocked;
                    end
                    StLocked: begin
                        if (idx != color_o) begin
                            color_o  <= idx;
                            change_o <= 1'b1;
                            if (change_count_o != CNT_MAX) begin
                                change_count_o <= change_count_o + CNT_W'(1);
                            end
                            if (is_err) begin
                                seq_err_o <= 1'b1;
                                if (err_count_o != CNT_MAX) begin
                                    err_count_o <= err_count_o + CNT_W'(1);
                                end
                            end
                        end
                    end
                    default: state_q <= StAcquire;
                endcase
            end
        end
    end

endmodule
